// File: rtl/controller_pkg.sv
// rtl/controller_pkg.sv - control_mode constants, sampler FSM states and float constants
package controller_pkg;

   localparam logic [1:0] MODE_POSITION     = 2'b00;
   localparam logic [1:0] MODE_VELOCITY     = 2'b01;
   localparam logic [1:0] MODE_DISPLACEMENT = 2'b10;
   localparam logic [1:0] MODE_NONE         = 2'b11;

   // Exponent that a value whose magnitude already has bit 31 set ends up with.
   localparam logic [7:0] EXP_TOP = 8'd158;

   typedef enum logic [2:0] {
      IDLE,
      CAPTURE,
      NORMALIZE,
      PACK,
      STROBE
   } fsm_state_t;

endpackage

// File: rtl/int_to_float_seq.sv
// rtl/int_to_float_seq.sv - shift-based signed int32 to IEEE-754 single converter
// One left shift per cycle until the magnitude is normalised; result truncates toward zero.
module int_to_float_seq
   import controller_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] value,
   output logic        done,
   output logic [31:0] result
);

   logic        running;
   logic        sign;
   logic [31:0] mag;
   logic [7:0]  exponent;
   logic        finished;

   assign finished = (mag == 32'd0) || mag[31];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         running  <= 1'b0;
         sign     <= 1'b0;
         mag      <= '0;
         exponent <= '0;
      end else if (start) begin
         running  <= 1'b1;
         sign     <= value[31];
         mag      <= value[31] ? (~value + 32'd1) : value;
         exponent <= EXP_TOP;
      end else if (running) begin
         if (finished) begin
            running <= 1'b0;
         end else begin
            mag      <= mag << 1;
            exponent <= exponent - 8'd1;
         end
      end
   end

   // mag/exponent hold once normalised, so result stays valid after done.
   assign done   = running && finished;
   assign result = (mag == 32'd0) ? 32'd0 : {sign, exponent, mag[30:8]};

endmodule

// File: rtl/controller_state_sampler.sv
// rtl/controller_state_sampler.sv - periodic measurement sampler feeding the PID stage
// Each update tick captures the selected measurement and emits it as a float with a strobe.
module controller_state_sampler
   import controller_pkg::*;
#(
   parameter int UPDATE_DIV = 50000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic [1:0]  control_mode,
   input  logic [31:0] position,
   input  logic [31:0] displacement,
   output logic [31:0] state,
   output logic [31:0] velocity,
   output logic        update_controller,
   output logic        busy
);

   localparam int CW = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;

   logic [CW-1:0] count;
   logic          tick;
   fsm_state_t    fsm;
   logic [31:0]   pos_prev;
   logic          first_sample;
   logic [31:0]   new_velocity;
   logic [31:0]   source;
   logic          start;
   logic          conv_done;
   logic [31:0]   result;

   assign tick = enable && (count == CW'(UPDATE_DIV - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (!enable || tick) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   assign new_velocity = first_sample ? 32'd0 : (position - pos_prev);

   always_comb begin
      source = 32'd0;
      case (control_mode)
         MODE_POSITION:     source = position;
         MODE_VELOCITY:     source = new_velocity;
         MODE_DISPLACEMENT: source = displacement;
         default:           source = 32'd0;
      endcase
   end

   assign start = (fsm == CAPTURE);

   int_to_float_seq u_convert (
      .clock  (clock),
      .reset  (reset),
      .start  (start),
      .value  (source),
      .done   (conv_done),
      .result (result)
   );

   // Ticks outside IDLE are dropped on purpose: a late sample is worse than a skipped one.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fsm               <= IDLE;
         state             <= '0;
         velocity          <= '0;
         update_controller <= 1'b0;
         busy              <= 1'b0;
         pos_prev          <= '0;
         first_sample      <= 1'b1;
      end else begin
         update_controller <= 1'b0;
         case (fsm)
            IDLE: begin
               if (tick) begin
                  fsm  <= CAPTURE;
                  busy <= 1'b1;
               end
            end
            CAPTURE: begin
               velocity     <= new_velocity;
               pos_prev     <= position;
               first_sample <= 1'b0;
               fsm          <= NORMALIZE;
            end
            NORMALIZE: begin
               if (conv_done) fsm <= PACK;
            end
            PACK: begin
               state             <= result;
               update_controller <= 1'b1;
               fsm               <= STROBE;
            end
            STROBE: begin
               busy <= 1'b0;
               fsm  <= IDLE;
            end
            default: begin
               busy <= 1'b0;
               fsm  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_controller_state_sampler.sv
// tb/tb_controller_state_sampler.sv - scoreboard bench for controller_state_sampler
module tb_controller_state_sampler;

   localparam int DIV = 40;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [1:0]  control_mode = 2'b00;
   logic [31:0] position = '0;
   logic [31:0] displacement = '0;
   logic [31:0] state;
   logic [31:0] velocity;
   logic        update_controller;
   logic        busy;

   always #5 clock = ~clock;

   controller_state_sampler #(.UPDATE_DIV(DIV)) dut (
      .clock             (clock),
      .reset             (reset),
      .enable            (enable),
      .control_mode      (control_mode),
      .position          (position),
      .displacement      (displacement),
      .state             (state),
      .velocity          (velocity),
      .update_controller (update_controller),
      .busy              (busy)
   );

   typedef struct {
      logic [31:0] st;
      logic [31:0] vel;
      int          at;
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int strobes = 0;

   int          cnt = 0;
   bit          pending = 0;
   int          tick_cyc = 0;
   int          conv_lo = 1;
   int          conv_hi = 0;
   bit          first = 1;
   logic [31:0] prev = '0;

   // Float value of a signed int32, truncated; shifts = leading zeros of the magnitude.
   function automatic logic [31:0] to_float(input logic [31:0] v, output int shifts);
      logic [31:0] mag;
      logic [31:0] frac;
      int p;
      shifts = 0;
      if (v == 32'd0) return 32'd0;
      mag = v[31] ? (~v + 32'd1) : v;
      p = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) p = i;
      shifts = 31 - p;
      frac = mag - (32'd1 << p);
      if (p >= 23) frac = frac >> (p - 23);
      else frac = frac << (23 - p);
      return {v[31], 8'(127 + p), frac[22:0]};
   endfunction

   // Reference model, evaluated at each rising edge on the values the DUT samples.
   initial begin
      forever begin
         int cur;
         int sh;
         logic [31:0] vel;
         logic [31:0] src;
         exp_t e;
         @(posedge clock);
         cur = cyc;
         cyc = cyc + 1;
         if (reset) begin
            cnt = 0; pending = 0; conv_lo = 1; conv_hi = 0;
            first = 1; prev = '0;
            sb.delete();
         end else begin
            if (pending) begin
               vel = first ? 32'd0 : position - prev;
               prev = position;
               first = 0;
               case (control_mode)
                  2'b00: src = position;
                  2'b01: src = vel;
                  2'b10: src = displacement;
                  default: src = 32'd0;
               endcase
               e.st = to_float(src, sh);
               e.vel = vel;
               e.at = tick_cyc + 4 + sh;
               sb.push_back(e);
               conv_hi = e.at;
               pending = 0;
            end
            if (enable) begin
               if (cnt == DIV - 1) begin
                  cnt = 0;
                  if (cur > conv_hi) begin
                     pending = 1;
                     tick_cyc = cur;
                     conv_lo = cur + 1;
                     conv_hi = 32'h3fffffff;
                  end
               end else begin
                  cnt = cnt + 1;
               end
            end else begin
               cnt = 0;
            end
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT strobes.
   initial begin
      forever begin
         bit exp_busy;
         exp_t e;
         @(negedge clock);
         if (!reset) begin
            exp_busy = (cyc >= conv_lo) && (cyc <= conv_hi);
            checks++;
            if (busy !== exp_busy) begin
               errors++;
               $display("FAIL busy cycle %0d got %0b want %0b", cyc, busy, exp_busy);
            end
            if (update_controller === 1'b1) begin
               strobes++;
               if (sb.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_strobe cycle %0d state %h", cyc, state);
               end else begin
                  e = sb.pop_front();
                  checks++;
                  if (state !== e.st) begin
                     errors++;
                     $display("FAIL state cycle %0d got %h want %h", cyc, state, e.st);
                  end
                  checks++;
                  if (velocity !== e.vel) begin
                     errors++;
                     $display("FAIL velocity cycle %0d got %h want %h", cyc, velocity, e.vel);
                  end
                  checks++;
                  if (cyc != e.at) begin
                     errors++;
                     $display("FAIL strobe_cycle got %0d want %0d", cyc, e.at);
                  end
               end
            end
         end
      end
   end

   task automatic check_reset_values(input string tag);
      checks++;
      if (state !== 32'd0 || velocity !== 32'd0 || update_controller !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s got state %h vel %h upd %b busy %b want all zero",
                  tag, state, velocity, update_controller, busy);
      end
   endtask

   task automatic wait_strobe(input string tag);
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (update_controller !== 1'b1 && n < 100);
      if (update_controller !== 1'b1) begin
         checks++; errors++;
         $display("FAIL %s_timeout got no strobe want strobe within 100 cycles", tag);
      end
   endtask

   task automatic wait_busy(input string tag);
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (busy !== 1'b1 && n < 100);
      if (busy !== 1'b1) begin
         checks++; errors++;
         $display("FAIL %s_timeout got busy 0 want busy within 100 cycles", tag);
      end
   endtask

   logic [1:0]  dmode [11] = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd2, 2'd0, 2'd1};
   logic [31:0] dpos  [11] = '{32'd100, 32'd250, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF,
                               32'd5, 32'd0, 32'd9, 32'h7FFFFFFF, 32'h80000000};
   logic [31:0] ddisp [11] = '{32'd7, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'd3, 32'd0,
                               32'hFFFFFFDB, 32'd0, 32'd0};

   initial begin
      int s0;
      logic [31:0] corner [5];
      corner = '{32'd0, 32'd1, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF};

      repeat (3) @(negedge clock);
      #1 check_reset_values("reset_values");
      #1 reset = 1'b0;

      for (int i = 0; i < 11; i++) begin
         @(negedge clock);
         control_mode = dmode[i];
         position     = dpos[i];
         displacement = ddisp[i];
         enable       = 1'b1;
         wait_strobe("directed");
      end

      // enable dropped mid-conversion: the strobe still fires, then nothing
      wait_busy("enable_low");
      enable = 1'b0;
      s0 = strobes;
      repeat (80) @(negedge clock);
      checks++;
      if (strobes != s0 + 1) begin
         errors++;
         $display("FAIL enable_low_strobes got %0d want %0d", strobes - s0, 1);
      end

      // reset pulsed while normalising a long shift
      control_mode = 2'b00;
      position     = 32'd1;
      enable       = 1'b1;
      wait_busy("reset_mid");
      repeat (5) @(negedge clock);
      #2 reset = 1'b1;
      #1 check_reset_values("reset_mid_values");
      repeat (2) @(negedge clock);
      #2 reset = 1'b0;
      s0 = strobes;
      repeat (DIV - 1) @(negedge clock);
      checks++;
      if (strobes != s0) begin
         errors++;
         $display("FAIL reset_mid_strobe got %0d want %0d", strobes - s0, 0);
      end

      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         control_mode = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0: position = $urandom;
            1: position = 32'($urandom_range(0, 20)) - 32'd10;
            2: position = corner[$urandom_range(0, 4)];
            default: position = $urandom >> $urandom_range(0, 31);
         endcase
         displacement = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 4)) - 32'd2;
         if ($urandom_range(0, 49) == 0) enable = ~enable;
      end

      enable = 1'b0;
      repeat (60) @(negedge clock);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
